// File: rtl/instruction_aligner.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module      : instruction_aligner                                           |
// | Description : Realigns 32-bit fetch words into an instruction stream, with  |
// |               RVC halfword realignment when COMPRESSED_EN is defined.       |
// | Revision    : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------------+
module instruction_aligner #(
   parameter logic [31:0] START_ADDR = 32'h00000000
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [31:0] mem_data_i,
   input  logic        mem_valid_i,
   output logic        mem_ready_o,
   input  logic        jump_i,
   input  logic [31:0] jump_target_i,
   output logic [31:0] instr_o,
   output logic        compressed_o,
   output logic [31:0] pc_o,
   output logic        instr_valid_o,
   input  logic        instr_ready_i
);

`ifdef COMPRESSED_EN
   logic [15:0] r_hb;
   logic        r_hb_valid;
   logic        r_skip_lo;
   logic [31:0] r_pc;

   logic [15:0] w_hb_nxt;
   logic        w_hb_valid_nxt;
   logic        w_skip_lo_nxt;
   logic [31:0] w_pc_nxt;
   logic [31:0] w_instr;
   logic        w_compressed;
   logic        w_valid;
   logic        w_ready;
   logic        w_hb_c;
   logic        w_lo_c;
   logic        w_fire;
   logic        w_unused_bit;

   assign w_unused_bit = jump_target_i[0];
   assign w_hb_c       = (r_hb[1:0] != 2'b11);
   assign w_lo_c       = (mem_data_i[1:0] != 2'b11);

   always_comb begin
      w_instr      = mem_data_i;
      w_compressed = 1'b0;
      w_valid      = 1'b0;
      w_ready      = 1'b0;
      if (r_hb_valid && w_hb_c) begin
         w_instr      = {16'h0000, r_hb};
         w_compressed = 1'b1;
         w_valid      = 1'b1;
      end else if (r_hb_valid) begin
         w_instr = {mem_data_i[15:0], r_hb};
         w_valid = mem_valid_i;
         w_ready = instr_ready_i;
      end else if (r_skip_lo) begin
         // Lower halfword lies before the jump target: swallow it.
         w_ready = 1'b1;
      end else if (w_lo_c) begin
         w_instr      = {16'h0000, mem_data_i[15:0]};
         w_compressed = 1'b1;
         w_valid      = mem_valid_i;
         w_ready      = instr_ready_i;
      end else begin
         w_valid = mem_valid_i;
         w_ready = instr_ready_i;
      end
      if (jump_i) begin
         w_valid = 1'b0;
         w_ready = 1'b1;
      end
   end

   assign w_fire = w_valid && instr_ready_i;

   always_comb begin
      w_hb_nxt       = r_hb;
      w_hb_valid_nxt = r_hb_valid;
      w_skip_lo_nxt  = r_skip_lo;
      w_pc_nxt       = r_pc;
      if (jump_i) begin
         w_pc_nxt       = {jump_target_i[31:1], 1'b0};
         w_hb_valid_nxt = 1'b0;
         w_skip_lo_nxt  = jump_target_i[1];
      end else if (w_fire) begin
         w_pc_nxt = r_pc + (w_compressed ? 32'd2 : 32'd4);
         if (r_hb_valid && w_hb_c) begin
            w_hb_valid_nxt = 1'b0;
         end else if (r_hb_valid || w_lo_c) begin
            w_hb_nxt       = mem_data_i[31:16];
            w_hb_valid_nxt = 1'b1;
         end
      end else if (!r_hb_valid && r_skip_lo && mem_valid_i) begin
         w_hb_nxt       = mem_data_i[31:16];
         w_hb_valid_nxt = 1'b1;
         w_skip_lo_nxt  = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_hb       <= 16'h0000;
         r_hb_valid <= 1'b0;
         r_skip_lo  <= START_ADDR[1];
         r_pc       <= {START_ADDR[31:1], 1'b0};
      end else begin
         r_hb       <= w_hb_nxt;
         r_hb_valid <= w_hb_valid_nxt;
         r_skip_lo  <= w_skip_lo_nxt;
         r_pc       <= w_pc_nxt;
      end
   end

   assign instr_o       = w_instr;
   assign compressed_o  = w_compressed;
   assign pc_o          = r_pc;
   assign instr_valid_o = reset_n && w_valid;
   assign mem_ready_o   = reset_n && w_ready;
`else
   logic [31:0] r_pc;
   logic [1:0]  w_unused_bits;
   logic        w_fire;

   assign w_unused_bits = jump_target_i[1:0];
   assign w_fire        = mem_valid_i && instr_ready_i && !jump_i;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_pc <= {START_ADDR[31:1], 1'b0};
      end else if (jump_i) begin
         r_pc <= {jump_target_i[31:2], 2'b00};
      end else if (w_fire) begin
         r_pc <= r_pc + 32'd4;
      end
   end

   // A jump still flushes whatever word is on the bus.
   assign instr_o       = mem_data_i;
   assign compressed_o  = 1'b0;
   assign pc_o          = r_pc;
   assign instr_valid_o = reset_n && mem_valid_i && !jump_i;
   assign mem_ready_o   = reset_n && (jump_i || instr_ready_i);
`endif

endmodule
`default_nettype wire

// File: tb/tb_instruction_aligner.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module      : tb_instruction_aligner                                        |
// | Description : Scoreboard bench for instruction_aligner (both COMPRESSED_EN  |
// |               builds).                                                      |
// | Revision    : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------------+
module tb_instruction_aligner;

   localparam logic [31:0] C_START = 32'h00000000;

   logic        clk;
   logic        reset_n;
   logic [31:0] mem_data_i;
   logic        mem_valid_i;
   logic        mem_ready_o;
   logic        jump_i;
   logic [31:0] jump_target_i;
   logic [31:0] instr_o;
   logic        compressed_o;
   logic [31:0] pc_o;
   logic        instr_valid_o;
   logic        instr_ready_i;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc;
      logic        comp;
      logic        mready;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] wq[$];
   int          checks = 0;
   int          errors = 0;

   instruction_aligner #(.START_ADDR(C_START)) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .mem_data_i    (mem_data_i),
      .mem_valid_i   (mem_valid_i),
      .mem_ready_o   (mem_ready_o),
      .jump_i        (jump_i),
      .jump_target_i (jump_target_i),
      .instr_o       (instr_o),
      .compressed_o  (compressed_o),
      .pc_o          (pc_o),
      .instr_valid_o (instr_valid_o),
      .instr_ready_i (instr_ready_i)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Output monitor: every handshake pops the next expected instruction.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (reset_n && instr_valid_o && instr_ready_i) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_output: instr %h pc %h, required no output", instr_o, pc_o);
            end else begin
               e = exp_q.pop_front();
               if (instr_o !== e.instr || pc_o !== e.pc || compressed_o !== e.comp || mem_ready_o !== e.mready) begin
                  errors++;
                  $display("FAIL out_item: got instr %h pc %h comp %b mready %b, required instr %h pc %h comp %b mready %b",
                           instr_o, pc_o, compressed_o, mem_ready_o, e.instr, e.pc, e.comp, e.mready);
               end
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   task automatic push_exp(input logic [31:0] i, input logic [31:0] p, input logic c, input logic m);
      exp_t e;
      e.instr = i; e.pc = p; e.comp = c; e.mready = m;
      exp_q.push_back(e);
   endtask

   // Memory model: presents queued words until the aligner accepts them.
   task automatic run_feed(input int budget);
      int  n;
      logic consumed;
      n = 0;
      while ((wq.size() > 0 || exp_q.size() > 0) && n < budget) begin
         if (wq.size() > 0) begin
            mem_valid_i = 1'b1;
            mem_data_i  = wq[0];
         end else begin
            mem_valid_i = 1'b0;
         end
         @(negedge clk);
         consumed = mem_valid_i && mem_ready_o;
         @(posedge clk); #1;
         if (consumed) void'(wq.pop_front());
         n++;
      end
      mem_valid_i = 1'b0;
      if (n >= budget) begin
         checks++;
         errors++;
         $display("FAIL feed_timeout: %0d words and %0d outputs left, required 0", wq.size(), exp_q.size());
         wq.delete();
         exp_q.delete();
      end
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      reset_n = 1'b0; jump_i = 1'b0; mem_valid_i = 1'b0; instr_ready_i = 1'b1;
      @(posedge clk); #1;
      reset_n = 1'b1;
   endtask

   task automatic do_jump(input logic [31:0] target);
      jump_i = 1'b1; jump_target_i = target;
      @(posedge clk); #1;
      jump_i = 1'b0; mem_valid_i = 1'b0;
   endtask

   task automatic test_reset();
      mem_valid_i = 1'b1; mem_data_i = 32'h00130093; instr_ready_i = 1'b1;
      @(negedge clk);
      checks++;
      if (instr_valid_o !== 1'b0 || mem_ready_o !== 1'b0) begin
         errors++;
         $display("FAIL reset_handshake: valid %b ready %b, required 0 0", instr_valid_o, mem_ready_o);
      end
      checks++;
      if (pc_o !== C_START) begin
         errors++;
         $display("FAIL reset_pc: got %h, required %h", pc_o, C_START);
      end
      @(posedge clk); #1;
      reset_n = 1'b1; mem_valid_i = 1'b0;
      @(negedge clk);
      checks++;
      if (mem_ready_o !== 1'b1 || instr_valid_o !== 1'b0) begin
         errors++;
         $display("FAIL post_reset: ready %b valid %b, required 1 0", mem_ready_o, instr_valid_o);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_pc_after(input logic [31:0] want);
      checks++;
      if (pc_o !== want) begin
         errors++;
         $display("FAIL pc_after: got %h, required %h", pc_o, want);
      end
   endtask

`ifdef COMPRESSED_EN
   task automatic test_single();
      do_reset();
      wq.push_back(32'h00130093);
      push_exp(32'h00130093, 32'h0, 1'b0, 1'b1);
      run_feed(20);
      test_pc_after(32'h4);
   endtask

   task automatic test_pair();
      do_reset();
      wq.push_back(32'h45854505); wq.push_back(32'h00000013);
      push_exp(32'h00004505, 32'h0, 1'b1, 1'b1);
      push_exp(32'h00004585, 32'h2, 1'b1, 1'b0);
      push_exp(32'h00000013, 32'h4, 1'b0, 1'b1);
      run_feed(20);
      test_pc_after(32'h8);
   endtask

   task automatic test_split();
      do_reset();
      wq.push_back(32'h00934505); wq.push_back(32'h45050013);
      push_exp(32'h00004505, 32'h0, 1'b1, 1'b1);
      push_exp(32'h00130093, 32'h2, 1'b0, 1'b1);
      push_exp(32'h00004505, 32'h6, 1'b1, 1'b0);
      run_feed(20);
      test_pc_after(32'h8);
   endtask

   task automatic test_jump();
      do_reset();
      instr_ready_i = 1'b0; mem_valid_i = 1'b1; mem_data_i = 32'h00000013;
      jump_i = 1'b1; jump_target_i = 32'h00000102;
      @(negedge clk);
      checks++;
      if (instr_valid_o !== 1'b0 || mem_ready_o !== 1'b1) begin
         errors++;
         $display("FAIL jump_flush: valid %b ready %b, required 0 1", instr_valid_o, mem_ready_o);
      end
      @(posedge clk); #1;
      jump_i = 1'b0; mem_valid_i = 1'b0; instr_ready_i = 1'b1;
      test_pc_after(32'h102);
      wq.push_back(32'h00934505); wq.push_back(32'h45050013);
      push_exp(32'h00130093, 32'h102, 1'b0, 1'b1);
      push_exp(32'h00004505, 32'h106, 1'b1, 1'b0);
      run_feed(20);
   endtask

   task automatic test_stall();
      do_reset();
      wq.push_back(32'h45854505);
      push_exp(32'h00004505, 32'h0, 1'b1, 1'b1);
      run_feed(20);
      instr_ready_i = 1'b0; mem_valid_i = 1'b0; mem_data_i = 32'h00000013;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         checks++;
         if (instr_o !== 32'h00004585 || pc_o !== 32'h2 || mem_ready_o !== 1'b0 || instr_valid_o !== 1'b1) begin
            errors++;
            $display("FAIL stall_hold: instr %h pc %h ready %b valid %b, required 00004585 00000002 0 1",
                     instr_o, pc_o, mem_ready_o, instr_valid_o);
         end
         @(posedge clk); #1;
      end
      instr_ready_i = 1'b1;
      push_exp(32'h00004585, 32'h2, 1'b1, 1'b0);
      run_feed(20);
      test_pc_after(32'h4);
   endtask

   task automatic test_wrap();
      do_reset();
      mem_valid_i = 1'b0;
      do_jump(32'hFFFFFFFC);
      wq.push_back(32'h45854505); wq.push_back(32'h00000013);
      push_exp(32'h00004505, 32'hFFFFFFFC, 1'b1, 1'b1);
      push_exp(32'h00004585, 32'hFFFFFFFE, 1'b1, 1'b0);
      push_exp(32'h00000013, 32'h00000000, 1'b0, 1'b1);
      run_feed(20);
   endtask

   task automatic test_reset_mid();
      do_reset();
      wq.push_back(32'h00934505);
      push_exp(32'h00004505, 32'h0, 1'b1, 1'b1);
      run_feed(20);
      reset_n = 1'b0; mem_valid_i = 1'b1; mem_data_i = 32'h45050013;
      @(negedge clk);
      checks++;
      if (instr_valid_o !== 1'b0 || mem_ready_o !== 1'b0 || pc_o !== C_START) begin
         errors++;
         $display("FAIL reset_mid: valid %b ready %b pc %h, required 0 0 %h", instr_valid_o, mem_ready_o, pc_o, C_START);
      end
      @(posedge clk); #1;
      reset_n = 1'b1; mem_valid_i = 1'b0;
      wq.push_back(32'h00130093);
      push_exp(32'h00130093, 32'h0, 1'b0, 1'b1);
      run_feed(20);
   endtask
`else
   task automatic test_stream();
      do_reset();
      wq.push_back(32'h00130093); wq.push_back(32'h45854505); wq.push_back(32'h00000013);
      push_exp(32'h00130093, 32'h0, 1'b0, 1'b1);
      push_exp(32'h45854505, 32'h4, 1'b0, 1'b1);
      push_exp(32'h00000013, 32'h8, 1'b0, 1'b1);
      run_feed(20);
      test_pc_after(32'hC);
   endtask

   task automatic test_jump();
      do_reset();
      mem_valid_i = 1'b1; mem_data_i = 32'hDEADBEEF;
      do_jump(32'h00000103);
      test_pc_after(32'h100);
      wq.push_back(32'h00130093); wq.push_back(32'h00000013);
      push_exp(32'h00130093, 32'h100, 1'b0, 1'b1);
      push_exp(32'h00000013, 32'h104, 1'b0, 1'b1);
      run_feed(20);
   endtask

   task automatic test_stall();
      do_reset();
      instr_ready_i = 1'b0; mem_valid_i = 1'b1; mem_data_i = 32'h00130093;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         checks++;
         if (instr_o !== 32'h00130093 || pc_o !== 32'h0 || mem_ready_o !== 1'b0 || instr_valid_o !== 1'b1) begin
            errors++;
            $display("FAIL stall_hold: instr %h pc %h ready %b valid %b, required 00130093 00000000 0 1",
                     instr_o, pc_o, mem_ready_o, instr_valid_o);
         end
         @(posedge clk); #1;
      end
      instr_ready_i = 1'b1;
      wq.push_back(32'h00130093);
      push_exp(32'h00130093, 32'h0, 1'b0, 1'b1);
      run_feed(20);
      test_pc_after(32'h4);
   endtask

   task automatic test_wrap();
      do_reset();
      mem_valid_i = 1'b0;
      do_jump(32'hFFFFFFFE);
      test_pc_after(32'hFFFFFFFC);
      wq.push_back(32'h00000013); wq.push_back(32'h00130093);
      push_exp(32'h00000013, 32'hFFFFFFFC, 1'b0, 1'b1);
      push_exp(32'h00130093, 32'h00000000, 1'b0, 1'b1);
      run_feed(20);
   endtask

   task automatic test_reset_mid();
      do_reset();
      wq.push_back(32'h00130093); wq.push_back(32'h00000013);
      push_exp(32'h00130093, 32'h0, 1'b0, 1'b1);
      push_exp(32'h00000013, 32'h4, 1'b0, 1'b1);
      run_feed(20);
      reset_n = 1'b0; mem_valid_i = 1'b1; mem_data_i = 32'h45050013;
      @(negedge clk);
      checks++;
      if (instr_valid_o !== 1'b0 || mem_ready_o !== 1'b0 || pc_o !== C_START) begin
         errors++;
         $display("FAIL reset_mid: valid %b ready %b pc %h, required 0 0 %h", instr_valid_o, mem_ready_o, pc_o, C_START);
      end
      @(posedge clk); #1;
      reset_n = 1'b1; mem_valid_i = 1'b0;
      wq.push_back(32'h12345677);
      push_exp(32'h12345677, 32'h0, 1'b0, 1'b1);
      run_feed(20);
   endtask
`endif

   initial begin
      reset_n       = 1'b0;
      jump_i        = 1'b0;
      jump_target_i = 32'h0;
      mem_valid_i   = 1'b0;
      mem_data_i    = 32'h0;
      instr_ready_i = 1'b1;
      #1;
      test_reset();
`ifdef COMPRESSED_EN
      test_single();
      test_pair();
      test_split();
`else
      test_stream();
`endif
      test_jump();
      test_stall();
      test_wrap();
      test_reset_mid();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL leftover_outputs: %0d pending, required 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/instruction_aligner.md
INSTRUCTION_ALIGNER -- requirements
Module: instruction_aligner

Interface
REQ-001 SHALL have parameter: START_ADDR, 32'h00000000, PC and fetch position after reset.
REQ-002 SHALL have ports (name direction width meaning):
- clk  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- mem_data_i  in  32  fetched word, little-endian halfwords.
- mem_valid_i  in  1  mem_data_i valid.
- mem_ready_o  out  1  aligner consumes mem_data_i this cycle.
- jump_i  in  1  redirect/flush strobe.
- jump_target_i  in  32  redirect address; bit 0 ignored.
- instr_o  out  32  aligned instruction; compressed form in [15:0], [31:16] zero.
- compressed_o  out  1  instr_o is a 16-bit instruction, feeding the decompresser.
- pc_o  out  32  address of instr_o.
- instr_valid_o  out  1  instr_o valid.
- instr_ready_i  in  1  downstream accepts instr_o.

Function
REQ-003 SHALL hold state: hb[15:0] (buffered upper halfword), hb_valid, skip_lo, pc[31:0].
REQ-004 SHALL classify a halfword as compressed iff bits[1:0] != 2'b11.
REQ-005 SHALL drive outputs combinationally from state and mem_data_i, with zero added latency.
REQ-006 If hb_valid and hb is compressed, SHALL output {16'h0,hb}, compressed_o=1, instr_valid_o=1, mem_ready_o=0; on output handshake, hb_valid<=0.
REQ-007 If hb_valid and hb is not compressed, SHALL output {mem_data_i[15:0],hb}, compressed_o=0, instr_valid_o=mem_valid_i, mem_ready_o=instr_ready_i; on handshake, hb<=mem_data_i[31:16] and hb_valid stays 1.
REQ-008 If !hb_valid and skip_lo, SHALL set instr_valid_o=0 and mem_ready_o=1; on mem_valid_i, hb<=mem_data_i[31:16], hb_valid<=1, skip_lo<=0.
REQ-009 If !hb_valid, !skip_lo, and mem_data_i[15:0] is compressed, SHALL output {16'h0,mem_data_i[15:0]}, compressed_o=1, instr_valid_o=mem_valid_i, mem_ready_o=instr_ready_i; on handshake, hb<=mem_data_i[31:16] and hb_valid<=1.
REQ-010 If !hb_valid, !skip_lo, and mem_data_i[15:0] is not compressed, SHALL output mem_data_i, compressed_o=0, with valid/ready as REQ-009; on handshake, hb_valid stays 0.
REQ-011 On each output handshake, pc SHALL advance by 2 if compressed_o, else by 4; 32-bit wrap-around is permitted.
REQ-012 pc_o SHALL equal pc.
REQ-013 jump_i SHALL take priority over all handshakes in the same cycle:
- forces instr_valid_o=0 and mem_ready_o=1; any word presented is discarded.
- next state: pc<={jump_target_i[31:1],1'b0}, hb_valid<=0, skip_lo<=jump_target_i[1].
REQ-014 When instr_ready_i=0, instr_o, pc_o, and compressed_o SHALL remain stable while mem_data_i is stable; state SHALL not change.
REQ-015 A 32-bit instruction spanning two words SHALL be emitted once, with pc_o at its first halfword.

Reset
REQ-016 On reset_n low, asynchronously: pc<=START_ADDR with bit 0 cleared, hb<=16'h0, hb_valid<=0, skip_lo<=START_ADDR[1].
REQ-017 During reset, instr_valid_o=0 and mem_ready_o=0; outputs resume the cycle after deassertion.
REQ-018 Reset mid-split-instruction SHALL discard the buffered halfword.

Configuration
REQ-019 Macro COMPRESSED_EN SHALL enable RVC realignment (REQ-003..REQ-015).
REQ-020 Without COMPRESSED_EN, the block SHALL behave as follows:
- instr_o=mem_data_i, instr_valid_o=mem_valid_i, mem_ready_o=instr_ready_i.
- compressed_o=0.
- pc advances by 4; jump loads {jump_target_i[31:2],2'b00}.
- hb, hb_valid, and skip_lo are not implemented.

Verification
REQ-021 Word 32'h00130093 with ready held high -> one 32-bit instr 32'h00130093, compressed_o=0, pc_o 0->4.
REQ-022 Words 32'h45854505, 32'h00000013 -> outputs:
- 16'h4505 at pc 0, mem_ready_o=1.
- 16'h4585 at pc 2, mem_ready_o=0.
- 32'h00000013 at pc 4.
REQ-023 Words 32'h00934505, 32'h45050013 -> outputs:
- 16'h4505 at pc 0.
- split 32'h00130093 at pc 2.
- 16'h4505 at pc 6.
REQ-024 jump_i with target 32'h102, then word 32'h00934505 -> no output for the lower half; the next word completes a 32-bit instruction at pc_o 32'h102.
REQ-025 instr_ready_i=0 for 3 cycles with compressed hb buffered -> instr_o and pc_o constant; mem_ready_o=0; no pc advance.
REQ-026 Assert reset_n low while a split instruction is pending -> hb_valid cleared, pc_o=START_ADDR, instr_valid_o=0 during reset.
